// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: command-driven J/K controller for a WIDTH-bit bank of JK flip-flops.
// Define JK_SEQ_CHECK_EN to compare the bank result against the expected value in SETTLE.
module jk_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             bad_op,
  output logic             mismatch
);

  typedef enum logic [1:0] {IDLE, APPLY, COUNT, SETTLE} state_t;

  localparam logic [2:0] OP_HOLD   = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_CLEAR  = 3'd2;
  localparam logic [2:0] OP_SET    = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] OP_COUNT  = 3'd5;

  state_t           state, state_nxt;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic [LEN_W-1:0] cnt_r;
  logic             accept;
  logic             carry;

  assign accept    = cmd_valid && (state == IDLE);
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Command capture; the cycle counter only runs while counting.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      op_r   <= '0;
      data_r <= '0;
      cnt_r  <= '0;
    end else if (accept) begin
      op_r   <= cmd_op;
      data_r <= cmd_data;
      cnt_r  <= cmd_len;
    end else if (state == COUNT) begin
      cnt_r  <= cnt_r - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_op <= OP_TOGGLE)                     state_nxt = APPLY;
          else if (cmd_op == OP_COUNT && cmd_len != '0) state_nxt = COUNT;
          else                                          state_nxt = SETTLE;
        end
      end
      APPLY:   state_nxt = SETTLE;
      COUNT:   if (cnt_r == LEN_W'(1)) state_nxt = SETTLE;
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counting drives a synchronous up-counter: a bit toggles when all lower bits are 1.
  always_comb begin
    j      = '0;
    k      = '0;
    carry  = 1'b1;
    done   = (state == SETTLE);
    bad_op = (state == SETTLE) && (op_r > OP_COUNT);
    if (state == APPLY) begin
      case (op_r)
        OP_HOLD:   begin j = '0;     k = '0;      end
        OP_LOAD:   begin j = data_r; k = ~data_r; end
        OP_CLEAR:  begin j = '0;     k = '1;      end
        OP_SET:    begin j = '1;     k = '0;      end
        OP_TOGGLE: begin j = data_r; k = data_r;  end
        default:   begin j = '0;     k = '0;      end
      endcase
    end else if (state == COUNT) begin
      for (int i = 0; i < WIDTH; i++) begin
        j[i]  = carry;
        k[i]  = carry;
        carry = carry & q[i];
      end
    end
  end

`ifdef JK_SEQ_CHECK_EN
  logic [WIDTH-1:0] q0_r;
  logic [LEN_W-1:0] len_r;
  logic [WIDTH-1:0] expected;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      q0_r  <= '0;
      len_r <= '0;
    end else if (accept) begin
      q0_r  <= q;
      len_r <= cmd_len;
    end
  end

  always_comb begin
    expected = q0_r;
    case (op_r)
      OP_HOLD:   expected = q0_r;
      OP_LOAD:   expected = data_r;
      OP_CLEAR:  expected = '0;
      OP_SET:    expected = '1;
      OP_TOGGLE: expected = q0_r ^ data_r;
      OP_COUNT:  expected = q0_r + WIDTH'(len_r);
      default:   expected = q0_r;
    endcase
  end

  assign mismatch = (state == SETTLE) && (op_r <= OP_COUNT) && (q != expected);
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Scoreboard bench for jk_bank_sequencer: directed commands drive a modelled JK bank,
// and a monitor checks q, bad_op, mismatch and latency on every done pulse.
module tb_jk_bank_sequencer;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [7:0] cmd_len;
  logic [3:0] q;
  logic [3:0] j, k;
  logic       busy, done, bad_op, mismatch;

  logic [3:0] stuck_mask = 4'b0000;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  typedef struct {
    logic [3:0] q;
    logic       bad;
    logic       mis;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  jk_bank_sequencer #(.WIDTH(4), .LEN_W(8)) dut (
    .CLK(CLK), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len), .q(q),
    .j(j), .k(k), .busy(busy), .done(done), .bad_op(bad_op), .mismatch(mismatch)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // JK flip-flop bank; masked bits model cells stuck at 0.
  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) q <= 4'b0000;
    else        q <= ((j & ~q) | (~k & q)) & ~stuck_mask;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [3:0] data, input logic [7:0] len,
                               input logic [3:0] exp_q, input logic exp_bad, input logic exp_mis,
                               input int exp_lat, input bit track);
    int waited = 0;
    @(negedge CLK);
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    cmd_valid = 1'b1;
    while (!cmd_ready && waited < 500) begin
      @(negedge CLK);
      waited++;
    end
    if (!cmd_ready) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL ready_timeout: cmd_ready stayed 0, expected 1");
    end else if (track) begin
      sb.push_back('{q: exp_q, bad: exp_bad, mis: exp_mis, lat: exp_lat, acc: cyc + 1});
    end
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int waited = 0;
    while (sb.size() != 0 && waited < 1000) begin
      @(negedge CLK);
      waited++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_done: done=1 with no command outstanding, expected 0");
      end else begin
        mon_e = sb.pop_front();
        checkOutput("settle_q", int'(q), int'(mon_e.q));
        checkOutput("bad_op", int'(bad_op), int'(mon_e.bad));
        checkOutput("mismatch", int'(mismatch), int'(mon_e.mis));
        checkOutput("latency", cyc - mon_e.acc + 1, mon_e.lat);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 4'd0;
    cmd_len   = 8'd0;
    #2;
    checkOutput("reset_j", int'(j), 0);
    checkOutput("reset_k", int'(k), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    repeat (3) @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);
    checkOutput("ready_after_reset", int'(cmd_ready), 1);
    checkOutput("bank_after_reset", int'(q), 0);

    applyStimulus(3'd1, 4'b1010, 8'd0, 4'b1010, 1'b0, 1'b0, 2, 1'b1);
    checkOutput("load_j", int'(j), 4'b1010);
    checkOutput("load_k", int'(k), 4'b0101);
    checkOutput("load_busy", int'(busy), 1);

    applyStimulus(3'd4, 4'b0110, 8'd0, 4'b1100, 1'b0, 1'b0, 2, 1'b1);
    checkOutput("toggle_j", int'(j), 4'b0110);
    checkOutput("toggle_k", int'(k), 4'b0110);

    applyStimulus(3'd5, 4'b0000, 8'd5, 4'b0001, 1'b0, 1'b0, 6, 1'b1);
    checkOutput("count_first_j", int'(j), 4'b0001);
    checkOutput("count_first_k", int'(k), 4'b0001);

    applyStimulus(3'd2, 4'b0000, 8'd0, 4'b0000, 1'b0, 1'b0, 2, 1'b1);
    checkOutput("clear_k", int'(k), 4'b1111);

    applyStimulus(3'd5, 4'b0000, 8'd0, 4'b0000, 1'b0, 1'b0, 1, 1'b1);
    checkOutput("count0_j", int'(j), 0);
    checkOutput("count0_k", int'(k), 0);

    applyStimulus(3'd6, 4'b1111, 8'd3, 4'b0000, 1'b1, 1'b0, 1, 1'b1);
    checkOutput("illegal6_j", int'(j), 0);
    checkOutput("illegal6_k", int'(k), 0);

    applyStimulus(3'd3, 4'b0000, 8'd0, 4'b1111, 1'b0, 1'b0, 2, 1'b1);
    applyStimulus(3'd5, 4'b0000, 8'd20, 4'b0011, 1'b0, 1'b0, 21, 1'b1);
    applyStimulus(3'd0, 4'b1111, 8'd0, 4'b0011, 1'b0, 1'b0, 2, 1'b1);
    checkOutput("hold_j", int'(j), 0);
    applyStimulus(3'd4, 4'b1111, 8'd0, 4'b1100, 1'b0, 1'b0, 2, 1'b1);
    applyStimulus(3'd7, 4'b0101, 8'd0, 4'b1100, 1'b1, 1'b0, 1, 1'b1);
    applyStimulus(3'd5, 4'b0000, 8'd16, 4'b1100, 1'b0, 1'b0, 17, 1'b1);
    waitDrain();

`ifdef JK_SEQ_CHECK_EN
    stuck_mask = 4'b0001;
    applyStimulus(3'd3, 4'b0000, 8'd0, 4'b1110, 1'b0, 1'b1, 2, 1'b1);
    waitDrain();
    stuck_mask = 4'b0000;
`endif

    // Abort a long count with reset; no done may appear for it.
    applyStimulus(3'd5, 4'b0000, 8'd200, 4'b0000, 1'b0, 1'b0, 0, 1'b0);
    repeat (8) @(negedge CLK);
    checkOutput("midcount_busy", int'(busy), 1);
    checkOutput("midcount_j0", int'(j[0]), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_j", int'(j), 0);
    checkOutput("abort_k", int'(k), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    repeat (5) @(negedge CLK);
    checkOutput("recover_ready", int'(cmd_ready), 1);
    checkOutput("recover_bank", int'(q), 0);

    applyStimulus(3'd1, 4'b0101, 8'd0, 4'b0101, 1'b0, 1'b0, 2, 1'b1);
    waitDrain();
    repeat (3) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
